// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone bus arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_ERR  = 2'd2
    } state_t;

    localparam int unsigned M_IFETCH = 0;
    localparam int unsigned M_DATA   = 1;
    localparam int unsigned M_DMA    = 2;

    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after the last owner, modulo N.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (32'(last) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter with per-cycle bus lock and a watchdog that aborts hung slaves.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned N       = 3,
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    m_cyc_i,
    input  logic [N-1:0]    m_stb_i,
    input  logic [N-1:0]    m_we_i,
    input  logic [N*AW-1:0] m_adr_i,
    input  logic [N*DW-1:0] m_dat_i,
    output logic [N-1:0]    m_ack_o,
    output logic [N-1:0]    m_err_o,
    output logic [DW-1:0]   m_dat_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    output logic [N-1:0]    gnt_o,
    output logic            busy_o
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    state_t        state;
    logic [IW-1:0] last_gnt;
    logic [IW-1:0] owner;
    logic [7:0]    wd_cnt;
    logic [N-1:0]  pick;
    logic          wd_run;
    logic          wd_expire;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req  (m_cyc_i),
        .last (last_gnt),
        .gnt  (pick)
    );

    assign owner     = IW'(onehot_to_idx(32'(gnt_o)));
    assign wd_run    = m_stb_i[owner] && !s_ack_i;
    assign wd_expire = wd_run && (wd_cnt == 8'(TIMEOUT - 1));
    assign m_dat_o   = s_dat_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            gnt_o    <= '0;
            last_gnt <= IW'(N - 1);
            wd_cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    wd_cnt <= '0;
                    if (|m_cyc_i) begin
                        gnt_o <= pick;
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // cyc drop takes priority over a coincident watchdog expiry
                    if (!m_cyc_i[owner]) begin
                        last_gnt <= owner;
                        gnt_o    <= '0;
                        wd_cnt   <= '0;
                        state    <= ARB_IDLE;
                    end else if (wd_expire) begin
                        wd_cnt <= '0;
                        state  <= ARB_ERR;
                    end else if (wd_run) begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end else begin
                        wd_cnt <= '0;
                    end
                end
                ARB_ERR: begin
                    last_gnt <= owner;
                    gnt_o    <= '0;
                    wd_cnt   <= '0;
                    state    <= ARB_IDLE;
                end
                default: begin
                    gnt_o <= '0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        busy_o  = 1'b0;
        case (state)
            ARB_BUSY: begin
                busy_o         = 1'b1;
                s_cyc_o        = m_cyc_i[owner];
                s_stb_o        = m_stb_i[owner];
                s_we_o         = m_we_i[owner];
                s_adr_o        = m_adr_i[owner*AW +: AW];
                s_dat_o        = m_dat_i[owner*DW +: DW];
                m_ack_o[owner] = s_ack_i & m_stb_i[owner];
            end
            ARB_ERR: begin
                m_err_o[owner] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter: directed stimulus pushes expected grants/responses, monitors pop and compare.
module tb_wb_bus_arbiter;
    import wb_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  m_cyc_i, m_stb_i, m_we_i;
    logic [23:0] m_adr_i, m_dat_i;
    logic [2:0]  m_ack_o, m_err_o, gnt_o;
    logic [7:0]  m_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, busy_o;
    logic        ack_drv, auto_ack;

    assign s_ack_i = ack_drv | (auto_ack & s_stb_o);

    wb_bus_arbiter #(.N(3), .AW(8), .DW(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .gnt_o(gnt_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] gnt;
        logic [2:0] ack;
        logic [2:0] err;
        logic [7:0] adr;
        logic [7:0] wdat;
        logic [7:0] rdat;
        logic       we;
    } ev_t;

    ev_t        exp_q[$];
    logic [2:0] gnt_q[$];
    logic [2:0] prev_gnt = 3'b000;
    int         n_chk = 0;
    int         n_fail = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic ev_t ack_ev(input logic [2:0] g, input logic [7:0] adr,
                                   input logic [7:0] wdat, input logic we);
        ev_t e;
        e.gnt = g; e.ack = g; e.err = 3'b000;
        e.adr = adr; e.wdat = wdat; e.rdat = 8'h5A; e.we = we;
        return e;
    endfunction

    // Response monitor: any ack/err pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && (m_ack_o != 3'b000 || m_err_o != 3'b000)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got ack=%b err=%b expected none at %0t", m_ack_o, m_err_o, $time);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("resp_gnt", 32'(gnt_o), 32'(e.gnt));
                check("resp_ack", 32'(m_ack_o), 32'(e.ack));
                check("resp_err", 32'(m_err_o), 32'(e.err));
                if (e.err != 3'b000) begin
                    check("err_s_cyc", 32'(s_cyc_o), 32'd0);
                    check("err_s_stb", 32'(s_stb_o), 32'd0);
                end else begin
                    check("resp_adr", 32'(s_adr_o), 32'(e.adr));
                    check("resp_wdat", 32'(s_dat_o), 32'(e.wdat));
                    check("resp_we", 32'(s_we_o), 32'(e.we));
                    check("resp_rdat", 32'(m_dat_o), 32'(e.rdat));
                end
            end
        end
    end

    // Grant monitor: every new owner must match the expected order and follow an idle cycle.
    always @(negedge clk) begin
        if (gnt_o != prev_gnt && gnt_o != 3'b000) begin
            check("gnt_onehot", 32'($onehot(gnt_o)), 32'd1);
            check("gnt_idle_gap", 32'(prev_gnt), 32'd0);
            if (gnt_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_gnt: got %b expected none at %0t", gnt_o, $time);
            end else begin
                check("gnt_order", 32'(gnt_o), 32'(gnt_q.pop_front()));
            end
        end
        prev_gnt = gnt_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic serve(input int k);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_ack_o[k]) begin
                got = 1'b1;
                break;
            end
        end
        check("serve_ack_seen", 32'(got), 32'd1);
        tick();
        m_cyc_i[k] = 1'b0;
        m_stb_i[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [2:0] a;
        int         n_acks;
        int         k;
        bit         hit;

        rst = 1'b0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0;
        s_dat_i = 8'h5A; ack_drv = 1'b0; auto_ack = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        check("rst_s_stb", 32'(s_stb_o), 32'd0);
        check("rst_ack_err", 32'({m_ack_o, m_err_o}), 32'd0);
        tick();
        rst = 1'b1;

        // Single master write with a 2-cycle slave
        tick();
        m_adr_i = {8'hC2, 8'h3C, 8'hA0};
        m_dat_i = {8'h33, 8'hA5, 8'h11};
        m_we_i[M_DATA] = 1'b1;
        m_cyc_i[M_DATA] = 1'b1;
        m_stb_i[M_DATA] = 1'b1;
        gnt_q.push_back(3'b010);
        exp_q.push_back(ack_ev(3'b010, 8'h3C, 8'hA5, 1'b1));
        @(negedge clk);
        check("t1_latency_gnt", 32'(gnt_o), 32'd0);
        tick();
        @(negedge clk);
        check("t1_gnt", 32'(gnt_o), 32'b010);
        check("t1_s_cyc", 32'(s_cyc_o), 32'd1);
        check("t1_busy", 32'(busy_o), 32'd1);
        tick();
        tick();
        ack_drv = 1'b1;
        tick();
        ack_drv = 1'b0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        @(negedge clk);
        check("t1_ack_single", 32'(m_ack_o), 32'd0);
        tick();
        @(negedge clk);
        check("t1_idle_busy", 32'(busy_o), 32'd0);
        check("t1_idle_gnt", 32'(gnt_o), 32'd0);
        check("t1_idle_s_cyc", 32'(s_cyc_o), 32'd0);

        // Round robin, all masters requesting, 1-beat reads
        reset_pulse();
        m_dat_i = {8'h33, 8'h22, 8'h11};
        m_adr_i = {8'hC2, 8'hB1, 8'hA0};
        gnt_q.push_back(3'b001); gnt_q.push_back(3'b010);
        gnt_q.push_back(3'b100); gnt_q.push_back(3'b001);
        exp_q.push_back(ack_ev(3'b001, 8'hA0, 8'h11, 1'b0));
        exp_q.push_back(ack_ev(3'b010, 8'hB1, 8'h22, 1'b0));
        exp_q.push_back(ack_ev(3'b100, 8'hC2, 8'h33, 1'b0));
        exp_q.push_back(ack_ev(3'b001, 8'hA0, 8'h11, 1'b0));
        auto_ack = 1'b1;
        m_cyc_i = 3'b111; m_stb_i = 3'b111;
        n_acks = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            a = m_ack_o;
            tick();
            if (a != 3'b000) n_acks++;
            if (n_acks >= 4) begin
                m_cyc_i = '0; m_stb_i = '0;
                break;
            end
            m_cyc_i = ~a; m_stb_i = ~a;
        end
        check("rr_ack_count", 32'(n_acks), 32'd4);
        m_cyc_i = '0; m_stb_i = '0;
        auto_ack = 1'b0;
        tick();

        // Burst lock: DMA holds 4 beats while ifetch waits
        m_adr_i = {8'h50, 8'hB1, 8'h07};
        m_dat_i = {8'h99, 8'h22, 8'h11};
        m_we_i = 3'b100;
        gnt_q.push_back(3'b100); gnt_q.push_back(3'b001);
        m_cyc_i = 3'b101; m_stb_i = 3'b101;
        tick();
        for (int b = 0; b < 4; b++) begin
            tick();
            ack_drv = 1'b0;
            m_adr_i[M_DMA*8 +: 8] = 8'h50 + 8'(b);
            exp_q.push_back(ack_ev(3'b100, 8'h50 + 8'(b), 8'h99, 1'b1));
            tick();
            ack_drv = 1'b1;
        end
        tick();
        ack_drv = 1'b0;
        m_cyc_i[M_DMA] = 1'b0; m_stb_i[M_DMA] = 1'b0; m_we_i = '0;
        exp_q.push_back(ack_ev(3'b001, 8'h07, 8'h11, 1'b0));
        auto_ack = 1'b1;
        serve(M_IFETCH);
        auto_ack = 1'b0;
        tick();

        // Watchdog timeout on ifetch, then a late ack that must be ignored
        gnt_q.push_back(3'b001);
        exp_q.push_back('{gnt: 3'b001, ack: 3'b000, err: 3'b001, adr: 8'h00, wdat: 8'h00, rdat: 8'h00, we: 1'b0});
        m_cyc_i[M_IFETCH] = 1'b1; m_stb_i[M_IFETCH] = 1'b1;
        tick();
        k = -1;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_err_o != 3'b000) begin
                k = i;
                hit = 1'b1;
                break;
            end
        end
        check("to_seen", 32'(hit), 32'd1);
        check("to_latency", 32'(k), 32'd16);
        tick();
        m_cyc_i = '0; m_stb_i = '0;
        ack_drv = 1'b1;
        @(negedge clk);
        check("to_idle_busy", 32'(busy_o), 32'd0);
        check("to_idle_gnt", 32'(gnt_o), 32'd0);
        check("to_late_ack", 32'(m_ack_o), 32'd0);
        tick();
        ack_drv = 1'b0;

        // Asynchronous reset during a data-master transfer
        gnt_q.push_back(3'b010);
        m_cyc_i[M_DATA] = 1'b1; m_stb_i[M_DATA] = 1'b1;
        tick();
        @(negedge clk);
        check("ar_pre_busy", 32'(busy_o), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_s_cyc", 32'(s_cyc_o), 32'd0);
        check("ar_gnt", 32'(gnt_o), 32'd0);
        check("ar_busy", 32'(busy_o), 32'd0);
        check("ar_ack_err", 32'({m_ack_o, m_err_o}), 32'd0);
        tick();
        rst = 1'b1;
        m_cyc_i = 3'b011; m_stb_i = 3'b011;
        gnt_q.push_back(3'b001); gnt_q.push_back(3'b010);
        exp_q.push_back(ack_ev(3'b001, 8'h07, 8'h11, 1'b0));
        exp_q.push_back(ack_ev(3'b010, 8'hB1, 8'h22, 1'b0));
        auto_ack = 1'b1;
        serve(M_IFETCH);
        serve(M_DATA);
        auto_ack = 1'b0;
        tick();
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
